// File: rtl/prach_ditfft3_bf2_if.sv
// I/Q sample stream between the PRACH radix-3 stages, with the error flag of the stage that consumes it.
interface prach_ditfft3_bf2_if;
    logic signed [17:0] din_dr;
    logic signed [17:0] din_di;
    logic               din_dv;
    logic               sync_in;
    logic signed [17:0] dout_dr;
    logic signed [17:0] dout_di;
    logic               dout_dv;
    logic               sync_out;
    logic               err_out;

    modport master (
        output din_dr, din_di, din_dv, sync_in,
        input  dout_dr, dout_di, dout_dv, sync_out, err_out
    );

    modport slave (
        input  din_dr, din_di, din_dv, sync_in,
        output dout_dr, dout_di, dout_dv, sync_out, err_out
    );
endinterface

// File: rtl/prach_ditfft3_bf2.sv
// Final PRACH radix-3 DIT stage: turns (x0, x1+x2, x2-x1) triples into y0, y1, y2.
// It uses a fixed 5-cycle latency, round-half-up and saturation on every output.
module prach_ditfft3_bf2 #(
    parameter int          OUT_SHIFT = 1,
    parameter logic [17:0] C_SQ3     = 18'd113512
) (
    input logic                clk,
    input logic                rst,
    prach_ditfft3_bf2_if.slave bus
);
    localparam int W    = 38;
    localparam int FRAC = 17;
    localparam logic signed [17:0]  COEF    = $signed(C_SQ3);
    localparam logic signed [W-1:0] HALF    = 38'sd1 <<< (FRAC - 1 + OUT_SHIFT);
    localparam logic signed [W-1:0] OUT_MAX = 38'sd131071;
    localparam logic signed [W-1:0] OUT_MIN = -38'sd131072;

    typedef enum logic [1:0] {IDX0 = 2'd0, IDX1 = 2'd1, IDX2 = 2'd2} slot_t;

    function automatic logic signed [17:0] to_out(input logic signed [W-1:0] v);
        logic signed [W-1:0] q;
        q = (v + HALF) >>> (FRAC + OUT_SHIFT);
        if (q > OUT_MAX)      to_out = OUT_MAX[17:0];
        else if (q < OUT_MIN) to_out = OUT_MIN[17:0];
        else                  to_out = q[17:0];
    endfunction

    slot_t cnt, idx, cnt_nxt;
    logic  viol;

    logic signed [17:0] cx0_dr, cx0_di, ca_dr, ca_di;
    logic signed [17:0] x0_dr, x0_di, a_dr, a_di, b_dr, b_di;
    logic signed [35:0] kb_dr, kb_di;
    logic signed [W-1:0] y0_dr, y0_di, y1_dr, y1_di, y2_dr, y2_di;
    logic signed [W-1:0] base_dr, base_di;
    logic signed [W-1:0] s0_dr, s0_di, s1_dr, s1_di, s2_dr, s2_di;
    logic signed [17:0] h1_dr, h1_di, h2_dr, h2_di;
    logic signed [17:0] out_dr, out_di;
    logic               v2, v3, v4, h1_ok, h2_ok;
    logic [4:0]         dv_d, sync_d;
    slot_t              slot_d [5];

    // A sync always restarts the triple; a gap or sync inside a triple is a violation.
    always_comb begin
        idx     = cnt;
        cnt_nxt = IDX0;
        viol    = 1'b0;
        if (bus.din_dv) begin
            if (bus.sync_in) begin
                idx  = IDX0;
                viol = (cnt != IDX0);
            end
            case (idx)
                IDX0:    cnt_nxt = IDX1;
                IDX1:    cnt_nxt = IDX2;
                default: cnt_nxt = IDX0;
            endcase
        end else begin
            viol = (cnt != IDX0);
        end
    end

    always_comb begin
        base_dr = (W'(x0_dr) <<< FRAC) - (W'(a_dr) <<< (FRAC - 1));
        base_di = (W'(x0_di) <<< FRAC) - (W'(a_di) <<< (FRAC - 1));
        s0_dr   = (W'(x0_dr) + W'(a_dr)) <<< FRAC;
        s0_di   = (W'(x0_di) + W'(a_di)) <<< FRAC;
        s1_dr   = base_dr - W'(kb_di);
        s1_di   = base_di + W'(kb_dr);
        s2_dr   = base_dr + W'(kb_di);
        s2_di   = base_di - W'(kb_dr);
    end

    // Slots of a triple that never completed carry a cleared ok flag and emit zero.
    always_comb begin
        out_dr = '0;
        out_di = '0;
        if (dv_d[4]) begin
            case (slot_d[4])
                IDX0: if (v4) begin
                    out_dr = to_out(y0_dr);
                    out_di = to_out(y0_di);
                end
                IDX1: if (h1_ok) begin
                    out_dr = h1_dr;
                    out_di = h1_di;
                end
                IDX2: if (h2_ok) begin
                    out_dr = h2_dr;
                    out_di = h2_di;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= IDX0;
            {cx0_dr, cx0_di, ca_dr, ca_di} <= '0;
            {x0_dr, x0_di, a_dr, a_di, b_dr, b_di} <= '0;
            {kb_dr, kb_di} <= '0;
            {y0_dr, y0_di, y1_dr, y1_di, y2_dr, y2_di} <= '0;
            {h1_dr, h1_di, h2_dr, h2_di} <= '0;
            {v2, v3, v4, h1_ok, h2_ok} <= '0;
            dv_d   <= '0;
            sync_d <= '0;
            for (int i = 0; i < 5; i++) slot_d[i] <= IDX0;
            bus.dout_dr  <= '0;
            bus.dout_di  <= '0;
            bus.dout_dv  <= 1'b0;
            bus.sync_out <= 1'b0;
            bus.err_out  <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            bus.err_out <= viol;
            if (bus.din_dv && idx == IDX0) begin
                cx0_dr <= bus.din_dr;
                cx0_di <= bus.din_di;
            end
            if (bus.din_dv && idx == IDX1) begin
                ca_dr <= bus.din_dr;
                ca_di <= bus.din_di;
            end
            // x0 and a move with b so the capture registers are free for the next triple.
            v2 <= bus.din_dv && idx == IDX2;
            if (bus.din_dv && idx == IDX2) begin
                b_dr  <= bus.din_dr;
                b_di  <= bus.din_di;
                x0_dr <= cx0_dr;
                x0_di <= cx0_di;
                a_dr  <= ca_dr;
                a_di  <= ca_di;
            end
            v3 <= v2;
            if (v2) begin
                kb_dr <= 36'(b_dr) * 36'(COEF);
                kb_di <= 36'(b_di) * 36'(COEF);
            end
            v4 <= v3;
            if (v3) begin
                y0_dr <= s0_dr;
                y0_di <= s0_di;
                y1_dr <= s1_dr;
                y1_di <= s1_di;
                y2_dr <= s2_dr;
                y2_di <= s2_di;
            end
            // y1/y2 wait in their own bank so a following triple can reuse the sum registers.
            h1_ok <= v4;
            h2_ok <= h1_ok;
            if (v4) begin
                h1_dr <= to_out(y1_dr);
                h1_di <= to_out(y1_di);
                h2_dr <= to_out(y2_dr);
                h2_di <= to_out(y2_di);
            end
            dv_d      <= {dv_d[3:0], bus.din_dv};
            sync_d    <= {sync_d[3:0], bus.din_dv & bus.sync_in};
            slot_d[0] <= idx;
            for (int i = 1; i < 5; i++) slot_d[i] <= slot_d[i-1];
            bus.dout_dv  <= dv_d[4];
            bus.sync_out <= sync_d[4];
            bus.dout_dr  <= out_dr;
            bus.dout_di  <= out_di;
        end
    end
endmodule

// File: tb/tb_prach_ditfft3_bf2.sv
// Self-checking bench: default-shift and zero-shift instances share one input stream.
// A complex-arithmetic reference model checks both of them.
module tb_prach_ditfft3_bf2;
    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst;

    prach_ditfft3_bf2_if bus ();
    prach_ditfft3_bf2_if bus0 ();

    assign bus0.din_dr  = bus.din_dr;
    assign bus0.din_di  = bus.din_di;
    assign bus0.din_dv  = bus.din_dv;
    assign bus0.sync_in = bus.sync_in;

    prach_ditfft3_bf2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prach_ditfft3_bf2 #(.OUT_SHIFT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    bit  e_dv [N];
    bit  e_sync [N];
    bit  e_err [N];
    int  e_dr [2][N];
    int  e_di [2][N];
    int  o_dr [2][N];
    int  o_di [2][N];
    bit  o_dv [N];
    bit  o_sync [N];
    bit  o_err [N];

    int  m_cnt = 0;
    real m_x0r, m_x0i, m_ar, m_ai;
    int  cyc = 0;
    int  vectors = 0;
    int  miscompares = 0;

    function automatic int fixq(real v, int sh);
        real s;
        s = $floor(v / (2.0 ** sh) + 0.5);
        if (s > 131071.0) return 131071;
        if (s < -131072.0) return -131072;
        return int'(s);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
        end
    endtask

    // Reference: y0 = x0+a, y1/y2 = x0 - a/2 +/- j*K*b, output 5 cycles after each sample.
    task automatic modelStep(input bit r, input bit v, input bit s, input int dr, input int di);
        real k, br, bi;
        int  sh;
        k = 113512.0 / 131072.0;
        if (r) begin
            m_cnt = 0;
            for (int j = cyc; j < cyc + 5; j++) begin
                e_dv[j] = 0;
                e_sync[j] = 0;
                for (int d = 0; d < 2; d++) begin
                    e_dr[d][j] = 0;
                    e_di[d][j] = 0;
                end
            end
            e_err[cyc] = 0;
        end else if (!v) begin
            e_err[cyc] = (m_cnt != 0);
            m_cnt = 0;
        end else begin
            e_err[cyc] = s && (m_cnt != 0);
            if (s) m_cnt = 0;
            e_dv[cyc+5] = 1;
            e_sync[cyc+5] = s;
            if (m_cnt == 0) begin
                m_x0r = real'(dr);
                m_x0i = real'(di);
            end else if (m_cnt == 1) begin
                m_ar = real'(dr);
                m_ai = real'(di);
            end else begin
                br = real'(dr);
                bi = real'(di);
                for (int d = 0; d < 2; d++) begin
                    sh = (d == 0) ? 1 : 0;
                    e_dr[d][cyc+3] = fixq(m_x0r + m_ar, sh);
                    e_di[d][cyc+3] = fixq(m_x0i + m_ai, sh);
                    e_dr[d][cyc+4] = fixq(m_x0r - m_ar / 2.0 - k * bi, sh);
                    e_di[d][cyc+4] = fixq(m_x0i - m_ai / 2.0 + k * br, sh);
                    e_dr[d][cyc+5] = fixq(m_x0r - m_ar / 2.0 + k * bi, sh);
                    e_di[d][cyc+5] = fixq(m_x0i - m_ai / 2.0 - k * br, sh);
                end
            end
            m_cnt = (m_cnt + 1) % 3;
        end
    endtask

    task automatic checkOutput();
        chk("dout_dv", bus.dout_dv, e_dv[cyc]);
        chk("sync_out", bus.sync_out, e_sync[cyc]);
        chk("err_out", bus.err_out, e_err[cyc]);
        chk("dout_dr", bus.dout_dr, e_dr[0][cyc]);
        chk("dout_di", bus.dout_di, e_di[0][cyc]);
        chk("sh0_dout_dv", bus0.dout_dv, e_dv[cyc]);
        chk("sh0_sync_out", bus0.sync_out, e_sync[cyc]);
        chk("sh0_err_out", bus0.err_out, e_err[cyc]);
        chk("sh0_dout_dr", bus0.dout_dr, e_dr[1][cyc]);
        chk("sh0_dout_di", bus0.dout_di, e_di[1][cyc]);
        o_dv[cyc]    = bus.dout_dv;
        o_sync[cyc]  = bus.sync_out;
        o_err[cyc]   = bus.err_out;
        o_dr[0][cyc] = int'(bus.dout_dr);
        o_di[0][cyc] = int'(bus.dout_di);
        o_dr[1][cyc] = int'(bus0.dout_dr);
        o_di[1][cyc] = int'(bus0.dout_di);
    endtask

    task automatic applyStimulus(input bit r, input bit v, input bit s, input int dr, input int di);
        rst         = r;
        bus.din_dv  = v;
        bus.sync_in = s;
        bus.din_dr  = 18'(dr);
        bus.din_di  = 18'(di);
        modelStep(r, v, s, dr, di);
        @(posedge clk);
        #1;
        checkOutput();
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic triple(input bit s, input int x0r, input int x0i, input int ar, input int ai,
                          input int br, input int bi);
        applyStimulus(0, 1, s, x0r, x0i);
        applyStimulus(0, 1, 0, ar, ai);
        applyStimulus(0, 1, 0, br, bi);
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    function automatic int rnd18();
        return int'($urandom_range(262143)) - 131072;
    endfunction

    initial begin
        int t;
        bit v, s;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 5, 5);
        idle(1);

        $display("[TB] basic triple");
        t = cyc;
        triple(1, 1000, 0, 600, 0, 200, 0);
        idle(6);
        chk("plan1_y0_re", o_dr[0][t+5], 800);
        chk("plan1_y0_im", o_di[0][t+5], 0);
        chk("plan1_y1_re", o_dr[0][t+6], 350);
        chk("plan1_y1_im", o_di[0][t+6], 87);
        chk("plan1_y2_re", o_dr[0][t+7], 350);
        chk("plan1_y2_im", o_di[0][t+7], -87);
        chk("plan1_sync", o_sync[t+5], 1);

        $display("[TB] back-to-back random triples");
        triple(1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        for (int i = 0; i < 3; i++)
            triple(0, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        idle(3);
        triple(0, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        idle(3);
        triple(1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        idle(6);

        $display("[TB] saturation");
        t = cyc;
        triple(1, 131071, -131072, 131071, -131072, 0, 0);
        idle(6);
        chk("sat_y0_re", o_dr[1][t+5], 131071);
        chk("sat_y0_im", o_di[1][t+5], -131072);
        chk("sat_y1_re", o_dr[1][t+6], 65536);
        chk("sat_y1_im", o_di[1][t+6], -65536);

        $display("[TB] valid drop inside triple");
        t = cyc;
        applyStimulus(0, 1, 1, 4000, -3000);
        applyStimulus(0, 1, 0, 1200, 700);
        applyStimulus(0, 0, 0, 0, 0);
        idle(2);
        triple(1, -2500, 1800, 900, -400, 3000, 2500);
        idle(6);
        chk("dropA_err", o_err[t+2], 1);
        chk("dropA_dv", o_dv[t+5], 1);
        chk("dropA_data", o_dr[0][t+5], 0);

        $display("[TB] sync inside triple");
        applyStimulus(0, 1, 1, 7000, 100);
        applyStimulus(0, 1, 0, 300, 300);
        triple(1, -6000, 5000, 2000, -1000, 1500, 800);
        idle(6);

        $display("[TB] reset during a triple");
        applyStimulus(0, 1, 1, 9000, 9000);
        applyStimulus(0, 1, 0, 1000, 1000);
        applyStimulus(1, 1, 0, 500, 500);
        idle(8);
        triple(0, 1234, -4321, 2222, 1111, -3333, 4444);
        idle(6);

        $display("[TB] random stream");
        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(3) != 0);
            s = v && ($urandom_range(5) == 0);
            applyStimulus(0, v, s, rnd18(), rnd18());
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/prach_ditfft3_bf2.md
Name: prach_ditfft3_bf2

Overview:
- Second and final stage of the PRACH radix-3 DIT butterfly. It sits directly downstream of the first radix-3 stage.
- It consumes that stage's per-triple stream (x0, a = x1+x2, b = x2-x1).
- It produces the 3-point DFT outputs y0, y1, y2 in natural order, with fixed latency, rounding and saturation.
- Output is an 18-bit I/Q stream with sync and valid, in the same format as the input.

Parameters:
- OUT_SHIFT, 1, arithmetic right shift applied to full-precision results before rounding (0..2).
- C_SQ3, 113512, round(sqrt(3)/2 * 2^17), unsigned 18-bit coefficient.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- din_dr  in  18  signed real part of input sample.
- din_di  in  18  signed imaginary part of input sample.
- din_dv  in  1  input sample valid.
- sync_in  in  1  marks index-0 sample (x0) of a triple; only meaningful with din_dv=1.
- dout_dr  out  18  signed real part of output.
- dout_di  out  18  signed imaginary part of output.
- dout_dv  out  1  output valid.
- sync_out  out  1  marks y0 of the output triple.
- err_out  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs are 0, the triple counter is 0 and the delay lines are cleared.
- Triple counter cnt (0..2) advances on each din_dv and wraps 2->0.
- sync_in&din_dv forces the current sample to index 0, so cnt becomes 1 after that edge.
- Input order per triple: idx0 = x0, idx1 = a, idx2 = b.
- Each triple must occupy 3 consecutive cycles. Gaps are allowed only between triples (when cnt==0).
- Math (complex, j·(br,bi) = (-bi,br)):
  - y0 = x0 + a
  - y1 = x0 - a/2 + j·K·b
  - y2 = x0 - a/2 - j·K·b
  - K = C_SQ3/2^17.
- Internal precision:
  - a/2 is exact, keeping 1 fractional bit.
  - K·b is a full 36-bit product, keeping 17 fractional bits.
  - Sums are formed at 21 integer bits plus 17 fractional bits. No internal overflow.
- Output conversion, per component:
  - shift right by OUT_SHIFT;
  - round half up (add 0.5 LSB, floor);
  - saturate to [-131072, 131071].
- Pipeline, with t = cycle of x0:
  - t+2: b captured, x0 and a already registered.
  - t+3: K·b product registered.
  - t+4: y0, y1, y2 full-precision sums registered.
  - t+5: y0 rounded and saturated onto dout.
  - t+6: y1 onto dout.
  - t+7: y2 onto dout.
- Latency is 5 cycles for every sample. dout_dv and sync_out equal din_dv and sync_in delayed by 5 cycles.
- With back-to-back triples, the output is continuous with no bubbles. A new triple's computation must not corrupt the y1/y2 holding registers still draining; use a separate hold bank.
- Violation A: din_dv=0 while cnt!=0.
  - err_out pulses on that cycle.
  - cnt returns to 0 and the partial triple is discarded.
  - Its already-delayed dout_dv pulses still emit, with data 0.
- Violation B: sync_in&din_dv while cnt!=0.
  - err_out pulses on that cycle.
  - The partial triple is discarded and the sample is taken as new x0.
  - The discarded slots output 0.
- sync_in without din_dv is ignored.
- Reset asserted mid-operation: the pipeline is flushed and no stale dout_dv emits after reset deassertion.

Test Plan:
- Default params; triple x0=(1000,0), a=(600,0), b=(200,0) with sync on x0 -> 5 cycles later dout = (800,0), (350,87), (350,-87) on consecutive cycles; sync_out on first; err_out=0.
- Back-to-back 4 triples of random 16-bit data, sync on first only -> 12 contiguous dout_dv; each matches a bit-exact reference model.
- OUT_SHIFT=0; x0=a=(131071,-131072), b=0 -> y0 saturates to (131071,-131072); y1 = (65536,-65536).
- Gap between triples (3 idle cycles) -> output shows the same 3-cycle gap; values correct; no err_out.
- din_dv drops after idx1 -> err_out pulse that cycle; the 2 delayed outputs are 0 with dout_dv=1; the next synced triple is correct.
- rst asserted 2 cycles after x0 -> all outputs 0 during reset; no dout_dv afterwards until new input; cnt restarts at 0.
